// File: rtl/mul_div_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : mul_div_unit                                                   |
// | Purpose : Iterative shift-add multiplier / restoring divider, HI/LO out |
// | Revision: 1.0 - initial release                                          |
// +-------------------------------------------------------------------------+
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       MDControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int          CW     = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_FIX  = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(ITER - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem;

    assign w_a_neg = ~MDControl[0] & SrcA[WIDTH-1];
    assign w_b_neg = ~MDControl[0] & SrcB[WIDTH-1];
    assign w_a_mag = w_a_neg ? -SrcA : SrcA;
    assign w_b_mag = w_b_neg ? -SrcB : SrcB;

    // Multiply: accumulator upper half gathers partial sums, lower half holds the remaining multiplier bits.
    assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_next = {w_sum, acc_q[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_shift    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_ge       = w_shift >= {1'b0, opnd_q};
    assign w_diff     = w_shift[WIDTH-1:0] - opnd_q;
    assign w_div_next = w_ge ? {w_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {w_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign w_prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign w_quot = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = MDControl[1];
                    sa_d     = w_a_neg;
                    sb_d     = w_b_neg;
                    a_d      = SrcA;
                    opnd_d   = w_b_mag;
                    acc_d    = {{WIDTH{1'b0}}, w_a_mag};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? w_div_next : w_mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d  = w_prod[2*WIDTH-1:WIDTH];
                    lo_d  = w_prod[WIDTH-1:0];
                    dbz_d = 1'b0;
                end else if (opnd_q == '0) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d  = w_rem;
                    lo_d  = w_quot;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : tb_mul_div_unit                                               |
// | Purpose : Directed and model-checked bench for mul_div_unit             |
// | Revision: 1.0 - initial release                                          |
// +-------------------------------------------------------------------------+
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  MDControl;
    logic [31:0] SrcA, SrcB;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .MDControl(MDControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic rules.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        int          sa, sb;
        longint      la, lb, p, q, r;
        logic [63:0] up;
        sa = a; sb = b; la = sa; lb = sb;
        dbz = 1'b0;
        case (op)
            2'b00: begin p = la * lb; up = p; hi = up[63:32]; lo = up[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    dbz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    q = la / lb; r = la % lb;
                    up = q; lo = up[31:0];
                    up = r; hi = up[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    logic        m_busy, m_done, m_dbz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_dbz;
    int          m_left;
    logic [31:0] t_hi, t_lo;
    logic        t_dbz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
            p_hi <= '0; p_lo <= '0; p_dbz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    model(MDControl, SrcA, SrcB, t_hi, t_lo, t_dbz);
                    p_hi <= t_hi; p_lo <= t_lo; p_dbz <= t_dbz;
                    m_busy <= 1'b1;
                    m_left <= 33;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1;
                m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking && !rst) begin
            chk("busy", {63'b0, busy}, {63'b0, m_busy});
            chk("done", {63'b0, done}, {63'b0, m_done});
            chk("HI", {32'b0, HI}, {32'b0, m_hi});
            chk("LO", {32'b0, LO}, {32'b0, m_lo});
            if (m_done) chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, m_dbz});
        end
    end

    task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        MDControl = op; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        MDControl = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
    endtask

    // Counts edges after the start edge until done; optional stray start at cycle glitch.
    task automatic wait_done(input int glitch, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == glitch);
            if (cyc == glitch) begin MDControl = 2'b01; SrcA = 32'd5; SrcB = 32'd5; end
        end while (!done && cyc < 40);
        start = 1'b0;
    endtask

    task automatic run_dir(input string nm, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edbz, input int glitch);
        int cyc;
        @(negedge clk);
        do_start(op, a, b);
        wait_done(glitch, cyc);
        chk({nm, " latency"}, 64'(cyc), 64'd33);
        chk({nm, " HI"}, {32'b0, HI}, {32'b0, ehi});
        chk({nm, " LO"}, {32'b0, LO}, {32'b0, elo});
        chk({nm, " dbz"}, {63'b0, div_by_zero}, {63'b0, edbz});
    endtask

    initial begin
        int cyc, ndone;
        rst = 1'b1; start = 1'b0; MDControl = '0; SrcA = '0; SrcB = '0;
        #12;
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset dbz", {63'b0, div_by_zero}, 64'd0);
        chk("reset HI", {32'b0, HI}, 64'd0);
        chk("reset LO", {32'b0, LO}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;

        run_dir("mult zero",   2'b00, 32'd0,        32'd199999,   32'h0,        32'h0,        1'b0, 0);
        chk("busy after", {63'b0, busy}, 64'd0);
        run_dir("multu max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
        run_dir("mult -3*7",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
        run_dir("div -7/2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
        run_dir("div ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 0);
        run_dir("divu by 0",   2'b11, 32'd199999,   32'd0,        32'h00030D3F, 32'hFFFFFFFF, 1'b1, 0);
        run_dir("divu 199999/7", 2'b11, 32'd199999, 32'd7,        32'd2,        32'd28571,    1'b0, 0);
        run_dir("div -5 by 0", 2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0);
        run_dir("div 7/-2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
        run_dir("glitch start", 2'b00, 32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 5);

        // Second start issued in the done cycle of the first.
        @(negedge clk);
        do_start(2'b01, 32'd1000, 32'd3000);
        wait_done(0, cyc);
        chk("b2b first latency", 64'(cyc), 64'd33);
        chk("b2b first LO", {32'b0, LO}, 64'd3000000);
        do_start(2'b11, 32'd100, 32'd7);
        wait_done(0, cyc);
        chk("b2b second latency", 64'(cyc), 64'd33);
        chk("b2b second LO", {32'b0, LO}, 64'd14);
        chk("b2b second HI", {32'b0, HI}, 64'd2);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] b;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            @(negedge clk);
            do_start(2'(i), $urandom, b);
            wait_done(0, cyc);
            chk("random latency", 64'(cyc), 64'd33);
        end

        // Asynchronous reset in the middle of a MULTU.
        @(negedge clk);
        do_start(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid rst busy", {63'b0, busy}, 64'd0);
        chk("mid rst HI", {32'b0, HI}, 64'd0);
        chk("mid rst LO", {32'b0, LO}, 64'd0);
        #2 rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid rst no done", 64'(ndone), 64'd0);
        chk("mid rst busy idle", {63'b0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
